// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter:
// FSM state codes, access-width codes and the all-lanes byte enable.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2
   } arb_state_t;

   localparam logic       MEM_WIDTH_WORD = 1'b0;
   localparam logic       MEM_WIDTH_BYTE = 1'b1;
   localparam logic [3:0] BE_ALL         = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified memory bus between the arbiter (master) and memory (slave).
// Ports: bus_req/we/be/addr/wdata driven by master; bus_rdata/ack by slave.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  bus_req;
   logic                  bus_we;
   logic [3:0]            bus_be;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0] bus_wdata;
   logic [DATA_WIDTH-1:0] bus_rdata;
   logic                  bus_ack;

   modport master (
      output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit bus.
// Ports: width/lane/sign_ext select; wdata_in->wdata_out+be; rdata_in->rdata_out.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic        width,
   input  logic [1:0]  lane,
   input  logic        sign_ext,
   input  logic [31:0] wdata_in,
   input  logic [31:0] rdata_in,
   output logic [31:0] wdata_out,
   output logic [3:0]  be,
   output logic [31:0] rdata_out
);

   logic [7:0] b;

   always_comb begin
      b = 8'h00;
      unique case (lane)
         2'd0: b = rdata_in[7:0];
         2'd1: b = rdata_in[15:8];
         2'd2: b = rdata_in[23:16];
         2'd3: b = rdata_in[31:24];
         default: b = 8'h00;
      endcase
   end

   always_comb begin
      wdata_out = wdata_in;
      be        = BE_ALL;
      rdata_out = rdata_in;
      if (width == MEM_WIDTH_BYTE) begin
         wdata_out = {4{wdata_in[7:0]}};
         be        = 4'b0001 << lane;
         rdata_out = sign_ext ? {{24{b[7]}}, b} : {24'h0, b};
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and MEM stage; stalls, lane steering.
// Ports: if_* fetch side, dm_* data side, stall_*, bus (master modport).
// ARB_PERF_EN adds perf_if_wait/perf_dm_wait stall-cycle counters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
`ifdef ARB_PERF_EN
   ,
   parameter int PERF_WIDTH = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_valid,
   input  logic                  dm_req,
   input  logic                  dm_rw,
   input  logic                  dm_width,
   input  logic                  dm_sign_ext,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_done,
   output logic                  stall_if,
   output logic                  stall_mem,
   mem_port_arbiter_if.master    bus
`ifdef ARB_PERF_EN
   ,
   output logic [PERF_WIDTH-1:0] perf_if_wait,
   output logic [PERF_WIDTH-1:0] perf_dm_wait
`endif
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LOW = 'h3;

   arb_state_t state;
   logic       fprio;
   logic       drop;
   logic       we_q;
   logic       width_q;
   logic       sign_q;
   logic [1:0] lane_q;

   logic        fetch_ok;
   logic        data_ok;
   logic        grant_d;
   logic        grant_f;
   logic        idle;
   logic        a_width;
   logic        a_sign;
   logic [1:0]  a_lane;
   logic [31:0] al_wdata;
   logic [3:0]  al_be;
   logic [31:0] al_rdata;

   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_done;

   // A requester seeing its done pulse is still holding the old
   // request, so it is not eligible again until the next cycle.
   assign fetch_ok = if_req & ~if_flush & ~if_valid;
   assign data_ok  = dm_req & ~dm_done;
   assign grant_d  = data_ok & ~(fprio & fetch_ok);
   assign grant_f  = fetch_ok & ~grant_d;

   // Aligner sees live request fields at grant, latched ones at ack.
   assign idle    = (state == ST_IDLE);
   assign a_width = idle ? dm_width : width_q;
   assign a_lane  = idle ? dm_addr[1:0] : lane_q;
   assign a_sign  = idle ? dm_sign_ext : sign_q;

   mem_lane_align u_align (
      .width     (a_width),
      .lane      (a_lane),
      .sign_ext  (a_sign),
      .wdata_in  (dm_wdata),
      .rdata_in  (bus.bus_rdata),
      .wdata_out (al_wdata),
      .be        (al_be),
      .rdata_out (al_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         fprio         <= 1'b0;
         drop          <= 1'b0;
         we_q          <= 1'b0;
         width_q       <= 1'b0;
         sign_q        <= 1'b0;
         lane_q        <= 2'd0;
         if_rdata      <= '0;
         if_valid      <= 1'b0;
         dm_rdata      <= '0;
         dm_done       <= 1'b0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_be    <= 4'b0000;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
      end else begin
         if_valid <= 1'b0;
         dm_done  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (grant_d) begin
                  state         <= ST_DATA;
                  bus.bus_req   <= 1'b1;
                  bus.bus_we    <= dm_rw;
                  bus.bus_be    <= al_be;
                  bus.bus_addr  <= dm_addr & ~ADDR_LOW;
                  bus.bus_wdata <= al_wdata;
                  we_q          <= dm_rw;
                  width_q       <= dm_width;
                  sign_q        <= dm_sign_ext;
                  lane_q        <= dm_addr[1:0];
               end else if (grant_f) begin
                  state         <= ST_FETCH;
                  bus.bus_req   <= 1'b1;
                  bus.bus_we    <= 1'b0;
                  bus.bus_be    <= BE_ALL;
                  bus.bus_addr  <= if_addr & ~ADDR_LOW;
                  bus.bus_wdata <= '0;
                  fprio         <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (bus.bus_ack) begin
                  state       <= ST_IDLE;
                  bus.bus_req <= 1'b0;
                  if_valid    <= ~(drop | if_flush);
                  if_rdata    <= bus.bus_rdata;
                  drop        <= 1'b0;
               end else if (if_flush) begin
                  drop <= 1'b1;
               end
            end
            ST_DATA: begin
               if (bus.bus_ack) begin
                  state       <= ST_IDLE;
                  bus.bus_req <= 1'b0;
                  dm_done     <= 1'b1;
                  dm_rdata    <= we_q ? '0 : al_rdata;
                  fprio       <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_if_wait <= '0;
         perf_dm_wait <= '0;
      end else begin
         if (stall_if)  perf_if_wait <= perf_if_wait + 1'b1;
         if (stall_mem) perf_dm_wait <= perf_dm_wait + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Drives the bus slave side by hand with scripted bus_ack timing.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_rw;
   logic        dm_width;
   logic        dm_sign_ext;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_done;
   logic        stall_if;
   logic        stall_mem;
`ifdef ARB_PERF_EN
   logic [31:0] perf_if_wait;
   logic [31:0] perf_dm_wait;
`endif

   int n_cmp;
   int n_err;

   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

   mem_port_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_flush    (if_flush),
      .if_rdata    (if_rdata),
      .if_valid    (if_valid),
      .dm_req      (dm_req),
      .dm_rw       (dm_rw),
      .dm_width    (dm_width),
      .dm_sign_ext (dm_sign_ext),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .dm_done     (dm_done),
      .stall_if    (stall_if),
      .stall_mem   (stall_mem),
      .bus         (bus_if.master)
`ifdef ARB_PERF_EN
      ,
      .perf_if_wait (perf_if_wait),
      .perf_dm_wait (perf_dm_wait)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      if_req = 0; if_addr = 0; if_flush = 0;
      dm_req = 0; dm_rw = 0; dm_width = 0;
      dm_sign_ext = 0; dm_addr = 0; dm_wdata = 0;
      bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bus_req", bus_if.bus_req, 0);
      check("rst_bus_be", bus_if.bus_be, 0);
      check("rst_if_valid", if_valid, 0);
      check("rst_dm_done", dm_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single fetch, ack in first bus_req cycle
      if_req = 1; if_addr = 32'h0000_0102;
      #1;
      check("t1_c0_stall_if", stall_if, 1);
      check("t1_c0_bus_req", bus_if.bus_req, 0);
      step();
      check("t1_c1_bus_req", bus_if.bus_req, 1);
      check("t1_c1_bus_addr", bus_if.bus_addr, 32'h100);
      check("t1_c1_bus_be", bus_if.bus_be, 4'hF);
      check("t1_c1_bus_we", bus_if.bus_we, 0);
      check("t1_c1_stall_if", stall_if, 1);
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h1234_5678;
      step();
      check("t1_c2_if_valid", if_valid, 1);
      check("t1_c2_if_rdata", if_rdata, 32'h1234_5678);
      check("t1_c2_stall_if", stall_if, 0);
      check("t1_c2_bus_req", bus_if.bus_req, 0);
`ifdef ARB_PERF_EN
      check("t1_perf_if", perf_if_wait, 2);
`endif
      bus_if.bus_ack = 0; if_req = 0;
      step();
      check("t1_c3_if_valid", if_valid, 0);
      check("t1_c3_bus_req", bus_if.bus_req, 0);

      // 2: both request, flag clear -> data first, then fetch
      if_req = 1; if_addr = 32'h400;
      dm_req = 1; dm_rw = 0; dm_width = 0; dm_addr = 32'h501;
      step();
      check("t2_c1_bus_addr", bus_if.bus_addr, 32'h500);
      check("t2_c1_bus_we", bus_if.bus_we, 0);
      check("t2_c1_stall_mem", stall_mem, 1);
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hCAFE_F00D;
      step();
      check("t2_c2_dm_done", dm_done, 1);
      check("t2_c2_dm_rdata", dm_rdata, 32'hCAFE_F00D);
      check("t2_c2_stall_mem", stall_mem, 0);
      bus_if.bus_ack = 0; dm_req = 0;
      step();
      check("t2_c3_fetch_addr", bus_if.bus_addr, 32'h400);
      check("t2_c3_bus_req", bus_if.bus_req, 1);
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h0000_0013;
      step();
      check("t2_c4_if_valid", if_valid, 1);
      check("t2_c4_if_rdata", if_rdata, 32'h13);
      bus_if.bus_ack = 0; if_req = 0;
      step();
      // lone load sets the fetch-priority flag
      dm_req = 1; dm_addr = 32'h700;
      step();
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h1111_1111;
      step();
      check("t2_c7_dm_done", dm_done, 1);
      bus_if.bus_ack = 0; dm_req = 0;
      step();
      dm_req = 1; dm_addr = 32'h900;
      if_req = 1; if_addr = 32'h800;
      step();
      check("t2_flag_fetch_first", bus_if.bus_addr, 32'h800);
      check("t2_flag_stall_mem", stall_mem, 1);
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h0000_0033;
      step();
      check("t2_flag_if_valid", if_valid, 1);
      bus_if.bus_ack = 0; if_req = 0;
      step();
      check("t2_then_data_addr", bus_if.bus_addr, 32'h900);
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h2222_2222;
      step();
      check("t2_then_data_done", dm_done, 1);
      bus_if.bus_ack = 0; dm_req = 0;
      step();

      // 3: byte loads from lane 3, signed then unsigned
      dm_req = 1; dm_rw = 0; dm_width = 1;
      dm_sign_ext = 1; dm_addr = 32'h203;
      step();
      check("t3_bus_be", bus_if.bus_be, 4'b1000);
      check("t3_bus_addr", bus_if.bus_addr, 32'h200);
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h8012_3456;
      step();
      check("t3_sext_rdata", dm_rdata, 32'hFFFF_FF80);
      bus_if.bus_ack = 0; dm_req = 0;
      step();
      dm_req = 1; dm_sign_ext = 0;
      step();
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h8012_3456;
      step();
      check("t3_zext_rdata", dm_rdata, 32'h0000_0080);
      bus_if.bus_ack = 0; dm_req = 0;
      step();

      // 4: byte store 0xAB to 0x301
      dm_req = 1; dm_rw = 1; dm_width = 1;
      dm_addr = 32'h301; dm_wdata = 32'h1234_56AB;
      step();
      check("t4_bus_we", bus_if.bus_we, 1);
      check("t4_bus_be", bus_if.bus_be, 4'b0010);
      check("t4_bus_wdata", bus_if.bus_wdata, 32'hABAB_ABAB);
      check("t4_bus_addr", bus_if.bus_addr, 32'h300);
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hDEAD_BEEF;
      step();
      check("t4_dm_done", dm_done, 1);
      check("t4_store_rdata", dm_rdata, 0);
      bus_if.bus_ack = 0; dm_req = 0; dm_rw = 0; dm_width = 0;
      step();

      // 5: flush during a fetch with delayed ack
      if_req = 1; if_addr = 32'h1000;
      step();
      check("t5_c1_bus_req", bus_if.bus_req, 1);
      if_flush = 1; if_addr = 32'h2000;
      step();
      if_flush = 0;
      step();
      check("t5_c3_addr_held", bus_if.bus_addr, 32'h1000);
      step();
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hBAD0_BAD0;
      step();
      check("t5_dropped_valid", if_valid, 0);
      check("t5_stall_if", stall_if, 1);
      bus_if.bus_ack = 0;
      step();
      check("t5_refetch_addr", bus_if.bus_addr, 32'h2000);
      check("t5_refetch_req", bus_if.bus_req, 1);
      bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h0000_0055;
      step();
      check("t5_refetch_valid", if_valid, 1);
      check("t5_refetch_rdata", if_rdata, 32'h55);
      bus_if.bus_ack = 0; if_req = 0;
      step();

      // 6: async reset in the middle of a data access
      dm_req = 1; dm_rw = 1; dm_width = 0;
      dm_addr = 32'h40; dm_wdata = 32'h1;
      step();
      check("t6_bus_req_pre", bus_if.bus_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_bus_req_rst", bus_if.bus_req, 0);
      check("t6_bus_we_rst", bus_if.bus_we, 0);
      check("t6_bus_be_rst", bus_if.bus_be, 0);
      check("t6_bus_addr_rst", bus_if.bus_addr, 0);
      check("t6_dm_done_rst", dm_done, 0);
`ifdef ARB_PERF_EN
      check("t6_perf_if_rst", perf_if_wait, 0);
      check("t6_perf_dm_rst", perf_dm_wait, 0);
`endif
      dm_req = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("t6_idle_bus_req", bus_if.bus_req, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
